// File: rtl/brent_kung_diff_pipe.sv
// brent_kung_diff_pipe
//   Recovers operand B from a 12-bit adder's {carry, sum} result and its
//   operand A: out_opb = (in_sum - in_opa) mod 2^WIDTH. out_err flags pairs
//   that no WIDTH-bit B can produce (SUM < A, or SUM - A >= 2^WIDTH).
//   The subtract is a Brent-Kung parallel-prefix adder computing
//   in_sum + ~{1'b0, in_opa} + 1. It is split over two register stages:
//     stage 1: p/g vectors plus the up-sweep (reduction) tree
//     stage 2: down-sweep, carry-in merge, sum XOR and error flag (out_*)
//   The pipeline uses valid/ready flow control, with 2-cycle latency and
//   a throughput of 1 beat per cycle.
//
// Parameters
//   WIDTH  operand width; in_sum is WIDTH+1 bits
//   CNT_W  statistics counter width (only with BK_DIFF_STATS_EN)
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready has no path from in_valid
//   in_sum, in_opa        adder result {carry, sum} and operand A
//   out_valid / out_ready output handshake
//   out_opb, out_err      recovered operand B and error flag
//   stat_beats, stat_errs accepted-beat / error-result counters
//                         (present only when BK_DIFF_STATS_EN is defined)
//
// Optional feature macro: BK_DIFF_STATS_EN

module brent_kung_diff_pipe #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_opa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_opb,
  output logic             out_err
`ifdef BK_DIFF_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_beats,
  output logic [CNT_W-1:0] stat_errs
`endif
);

  // The prefix tree spans the WIDTH+1 operand bits. The carry out of its
  // top bit becomes result bit WIDTH+1.
  localparam int M    = WIDTH + 1;
  localparam int LVLS = $clog2(M);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic         adv1, adv2, s1_valid;
  logic [M-1:0] x_op, y_op, p_in, g_in, up_g, up_p;
  logic [M-1:0] s1_p, s1_g, s1_pp;
  logic [M-1:0] dn_g, dn_p;
  logic [M:0]   carry, diff;

  // Flow control: a stage advances when it is empty or its successor moves.
  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  // Stage 1 combinational: operand prep, p/g, up-sweep.
  // A is zero-extended, then inverted; the +1 is the tree's carry-in.
  always_comb begin
    x_op = in_sum;
    y_op = {1'b1, ~in_opa};
    p_in = x_op ^ y_op;
    g_in = x_op & y_op;
    // NOTE: blocking assignments in always_comb; each level reads the values
    // the previous level just produced, and every target gets a default first.
    up_g = g_in;
    up_p = p_in;
    for (int l = 0; l < LVLS; l++) begin
      for (int i = (2 << l) - 1; i < M; i += (2 << l)) begin
        up_g[i] = up_g[i] | (up_p[i] & up_g[i - (1 << l)]);
        up_p[i] = up_p[i] & up_p[i - (1 << l)];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) s1_valid <= 1'b0;
    else if (adv1) s1_valid <= in_valid;
  end

  // NOTE: datapath registers are not reset; they are only consumed while
  // their valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_p  <= p_in;
      s1_g  <= up_g;
      s1_pp <= up_pp_sel(up_p);
    end
  end

  function automatic logic [M-1:0] up_pp_sel(input logic [M-1:0] v);
    return v;
  endfunction

  // Stage 2 combinational: down-sweep fills the remaining prefix positions.
  // After it, (dn_g[i], dn_p[i]) covers bits [i:0]. The carry-in of 1
  // then turns each prefix into carry[i+1] = G | P.
  always_comb begin
    dn_g = s1_g;
    dn_p = s1_pp;
    for (int l = LVLS - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < M; i += (2 << l)) begin
        dn_g[i] = dn_g[i] | (dn_p[i] & dn_g[i - (1 << l)]);
        dn_p[i] = dn_p[i] & dn_p[i - (1 << l)];
      end
    end
    carry = {dn_g | dn_p, 1'b1};
    diff  = {1'b0, s1_p} ^ carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_opb   <= '0;
      out_err   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_opb <= diff[WIDTH-1:0];
        // No carry out of the top bit means a borrow (SUM < A). Bit WIDTH set
        // means the difference does not fit in WIDTH bits.
        out_err <= ~diff[WIDTH+1] | diff[WIDTH];
      end
    end
  end

`ifdef BK_DIFF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats <= '0;
      stat_errs  <= '0;
    end else begin
      if (in_valid && adv1) stat_beats <= stat_beats + CNT_W'(1);
      if (out_valid && out_ready && out_err) stat_errs <= stat_errs + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_brent_kung_diff_pipe.sv
// Directed and randomised self-checking bench for brent_kung_diff_pipe.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.

module tb_brent_kung_diff_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_sum;
  logic [11:0] in_opa;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_opb;
  logic        out_err;
`ifdef BK_DIFF_STATS_EN
  logic [15:0] stat_beats;
  logic [15:0] stat_errs;
`endif

  typedef struct packed {
    logic [11:0] opb;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  int   sb_beats = 0;
  int   sb_errs  = 0;

  brent_kung_diff_pipe #(.WIDTH(12), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_opa    (in_opa),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_opb   (out_opb),
    .out_err   (out_err)
`ifdef BK_DIFF_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_errs (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer subtraction.
  function automatic exp_t model(input logic [12:0] s, input logic [11:0] a);
    exp_t e;
    int   d;
    d     = int'(s) - int'(a);
    e.opb = d[11:0];
    e.err = (d < 0) || (d >= 4096);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of bookkeeping. Call it at a falling edge with the inputs set.
  // It scores transfers that the next rising edge will perform.
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      check("sb_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_opb", out_opb, e.opb);
        check("sb_err", out_err, e.err);
        if (e.err) sb_errs++;
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      sb_q.push_back(model(in_sum, in_opa));
      sb_beats++;
    end
    @(negedge clk);
  endtask

  // Single beat with an unstalled output: checks the 2-cycle latency and
  // the hand-computed result.
  task automatic one_beat(input string tag, input logic [12:0] s, input logic [11:0] a,
                          input logic [11:0] eo, input logic ee);
    in_valid  = 1'b1;
    in_sum    = s;
    in_opa    = a;
    out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    #1 check({tag, "_lat1"}, out_valid, 0);
    check({tag, "_in_ready2"}, in_ready, 1);
    step();
    #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_opb"}, out_opb, eo);
    check({tag, "_err"}, out_err, ee);
  endtask

  logic [12:0] bp_s [5];
  logic [11:0] bp_a [5];
  logic [11:0] held;
  int          k;
  int          budget;
  int          sent;

  initial begin
    bp_s = '{13'h0123, 13'h0FFF, 13'h0005, 13'h1800, 13'h0ABC};
    bp_a = '{12'h023, 12'h001, 12'h006, 12'h800, 12'hABC};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_sum    = '0;
    in_opa    = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_opb", out_opb, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed arithmetic vectors.
    one_beat("basic",     13'h0A5F, 12'h321, 12'h73E, 1'b0);
    one_beat("underflow", 13'h0010, 12'h020, 12'hFF0, 1'b1);
    one_beat("ovf_max",   13'h1FFF, 12'h000, 12'hFFF, 1'b1);
    one_beat("ovf_4096",  13'h1FFF, 12'hFFF, 12'h000, 1'b1);
    one_beat("max_ok",    13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
    one_beat("zero",      13'h0000, 12'h000, 12'h000, 1'b0);
    one_beat("equal",     13'h0555, 12'h555, 12'h000, 1'b0);
    one_beat("edge_4095", 13'h0FFF, 12'h000, 12'hFFF, 1'b0);
    one_beat("edge_4096", 13'h1000, 12'h000, 12'h000, 1'b1);
    one_beat("edge_m1",   13'h1000, 12'h001, 12'hFFF, 1'b0);
    in_valid = 1'b0;
    step();
    step();

    // Back-pressure: out_ready low for 4 cycles while 5 beats are offered.
    n_out     = 0;
    k         = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_sum   = bp_s[k];
      in_opa   = bp_a[k];
      #1;
      check("bp_in_ready", in_ready, (c < 2) ? 1 : 0);
      if (c == 2) held = out_opb;
      if (c == 3) begin
        check("bp_hold", out_opb, held);
        check("bp_first", out_opb, 12'h100);
      end
      if (in_ready) k++;
      step();
    end
    check("bp_accepted", k, 2);
    out_ready = 1'b1;
    #1;
    check("bp_both_full_ready", in_ready, 1);
    check("bp_both_full_valid", out_valid, 1);
    budget = 0;
    while (n_out < 5 && budget < 20) begin
      in_valid = (k < 5);
      if (k < 5) begin
        in_sum = bp_s[k];
        in_opa = bp_a[k];
      end
      #1;
      if (in_valid && in_ready) k++;
      step();
      budget++;
    end
    check("bp_results", n_out, 5);
    check("bp_queue_empty", sb_q.size(), 0);

    // Reset with both stages full: in-flight beats are discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 13'h0123;
    in_opa    = 12'h023;
    step();
    in_sum = 13'h0456;
    in_opa = 12'h056;
    step();
    #1;
    check("mid_full_in_ready", in_ready, 0);
    check("mid_full_out_valid", out_valid, 1);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    sb_beats = 0;
    sb_errs  = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    n_out     = 0;
    for (int c = 0; c < 3; c++) step();
    check("mid_rst_no_output", n_out, 0);
    one_beat("post_rst", 13'h0A5F, 12'h321, 12'h73E, 1'b0);

    // Randomised stream against the scoreboard.
    sent   = 0;
    budget = 0;
    while (sent < 10000 && budget < 60000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sum   = 13'($urandom);
      in_opa   = 12'($urandom);
      if ($urandom_range(0, 7) == 0) in_opa = in_sum[11:0];
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) sent++;
      step();
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while (sb_q.size() != 0 && budget < 10) begin
      step();
      budget++;
    end
    check("rand_sent", sent, 10000);
    check("rand_drained", sb_q.size(), 0);
`ifdef BK_DIFF_STATS_EN
    check("stat_beats", stat_beats, sb_beats & 32'hFFFF);
    check("stat_errs", stat_errs, sb_errs & 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
